rtc_read_seq: RTL

- Read-side bus sequencer for the external RTC's multiplexed address/data bus.
- Complements the write-data path: on a start pulse it reads six consecutive time registers (seconds, minutes, hours, day, month, year).
- Each register is read with an address phase followed by a data phase on the shared AD bus.
- Captured bytes are published together to the display/control logic, with a one-cycle done pulse.

---
 rtl/rtc_read_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rtc_read_seq.sv
`default_nettype none
// ============================================================================
// Module   : rtc_read_seq
// Purpose  : Reads six RTC time registers over the multiplexed AD bus and
//            publishes them together with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_read_seq #(
    parameter logic [7:0]  BASE_ADDR = 8'h21,
    parameter int unsigned T_PULSE   = 4,
    parameter int unsigned T_GAP     = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] seconds,
    output logic [7:0] minutes,
    output logic [7:0] hours,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] year,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_GAP_A = 3'd2,
        S_DATA  = 3'd3,
        S_GAP_D = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] c_pulse_last = 8'(T_PULSE - 1);
    localparam logic [7:0] c_gap_last   = 8'(T_GAP - 1);
    localparam logic [2:0] c_last_idx   = 3'd5;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_idx;
    logic [7:0] r_sh0, r_sh1, r_sh2, r_sh3, r_sh4, r_sh5;

    logic       w_pulse_end;
    logic       w_gap_end;
    logic [7:0] w_next_addr;

    assign w_pulse_end = (r_cnt == c_pulse_last);
    assign w_gap_end   = (r_cnt == c_gap_last);
    assign w_next_addr = BASE_ADDR + {5'd0, r_idx + 3'd1};

    // Outputs are computed for the state being entered, so every pin is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= 3'd0;
            r_sh0   <= 8'h00;
            r_sh1   <= 8'h00;
            r_sh2   <= 8'h00;
            r_sh3   <= 8'h00;
            r_sh4   <= 8'h00;
            r_sh5   <= 8'h00;
            seconds <= 8'h00;
            minutes <= 8'h00;
            hours   <= 8'h00;
            day     <= 8'h00;
            month   <= 8'h00;
            year    <= 8'h00;
            ad_out  <= 8'h00;
            ad_oe   <= 1'b0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            ad_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ADDR;
                        r_cnt   <= 8'd0;
                        r_idx   <= 3'd0;
                        busy    <= 1'b1;
                        cs_n    <= 1'b0;
                        wr_n    <= 1'b0;
                        ad_n    <= 1'b0;
                        ad_oe   <= 1'b1;
                        ad_out  <= BASE_ADDR;
                    end
                end

                S_ADDR: begin
                    if (w_pulse_end) begin
                        // ad_oe/ad_out stay put for one cycle of address hold
                        r_state <= S_GAP_A;
                        r_cnt   <= 8'd0;
                        cs_n    <= 1'b1;
                        wr_n    <= 1'b1;
                        ad_n    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_GAP_A: begin
                    ad_oe <= 1'b0;
                    if (w_gap_end) begin
                        r_state <= S_DATA;
                        r_cnt   <= 8'd0;
                        cs_n    <= 1'b0;
                        rd_n    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_DATA: begin
                    if (w_pulse_end) begin
                        case (r_idx)
                            3'd0:    r_sh0 <= ad_in;
                            3'd1:    r_sh1 <= ad_in;
                            3'd2:    r_sh2 <= ad_in;
                            3'd3:    r_sh3 <= ad_in;
                            3'd4:    r_sh4 <= ad_in;
                            default: r_sh5 <= ad_in;
                        endcase
                        r_state <= S_GAP_D;
                        r_cnt   <= 8'd0;
                        cs_n    <= 1'b1;
                        rd_n    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_GAP_D: begin
                    if (w_gap_end) begin
                        r_cnt <= 8'd0;
                        if (r_idx == c_last_idx) begin
                            r_state <= S_DONE;
                            seconds <= r_sh0;
                            minutes <= r_sh1;
                            hours   <= r_sh2;
                            day     <= r_sh3;
                            month   <= r_sh4;
                            year    <= r_sh5;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= S_ADDR;
                            r_idx   <= r_idx + 3'd1;
                            cs_n    <= 1'b0;
                            wr_n    <= 1'b0;
                            ad_n    <= 1'b0;
                            ad_oe   <= 1'b1;
                            ad_out  <= w_next_addr;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                    ad_oe   <= 1'b0;
                    cs_n    <= 1'b1;
                    rd_n    <= 1'b1;
                    wr_n    <= 1'b1;
                    ad_n    <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
